// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory responder
package imem_pkg;

   localparam int IMEM_ADDR_WIDTH  = 32;
   localparam int IMEM_DATA_WIDTH  = 32;
   localparam int IMEM_MAX_LATENCY = 15;
   localparam int IMEM_CNT_WIDTH   = $clog2(IMEM_MAX_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } imem_state_t;

endpackage

// File: rtl/imem_store.sv
// rtl/imem_store.sv - single-clock instruction word RAM, one write port, one registered read port
module imem_store #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic                           re,
   input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
   output logic [DATA_WIDTH-1:0]          rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   // Non-blocking write and read on the same edge returns the old word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency instruction fetch responder; IMEM_ALIGN_CHECK_EN flags misaligned fetches
module imem_responder
   import imem_pkg::*;
#(
   parameter int ADDR_WIDTH  = IMEM_ADDR_WIDTH,
   parameter int DATA_WIDTH  = IMEM_DATA_WIDTH,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [ADDR_WIDTH-1:0]          instruction_addr,
   input  logic                           instruction_fetch_activate,
   output logic [DATA_WIDTH-1:0]          instruction_data,
   output logic                           instruction_fetch_done,
   output logic                           instruction_fetch_error,
   input  logic                           load_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0]          load_data
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   imem_state_t               state_q, state_d;
   logic [IMEM_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]     cap_addr_q;
   logic [ADDR_WIDTH-1:0]     sel_addr;
   logic                      capture;
   logic                      rd_en;
   logic                      out_of_range;
   logic                      misaligned;
   logic                      done_q;
   logic                      err_q;
   logic [DATA_WIDTH-1:0]     rd_data;

   // A capture that lands directly in RESP must read the live address, not the stale capture.
   assign sel_addr = capture ? instruction_addr : cap_addr_q;

   generate
      if (ADDR_WIDTH - 2 > IDX_W) begin : g_range
         assign out_of_range = |sel_addr[ADDR_WIDTH-1:IDX_W+2];
      end else begin : g_no_range
         assign out_of_range = 1'b0;
      end
   endgenerate

`ifdef IMEM_ALIGN_CHECK_EN
   assign misaligned = |sel_addr[1:0];
`else
   logic [1:0] unused_lsb;
   assign unused_lsb = sel_addr[1:0];
   assign misaligned = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      rd_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (instruction_fetch_activate) capture = 1'b1;
         end
         WAIT: begin
            if (!instruction_fetch_activate) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (instruction_addr != cap_addr_q) begin
               capture = 1'b1;
            end else if (cnt_q <= IMEM_CNT_WIDTH'(1)) begin
               state_d = RESP;
               cnt_d   = '0;
               rd_en   = 1'b1;
            end else begin
               cnt_d = cnt_q - IMEM_CNT_WIDTH'(1);
            end
         end
         RESP: begin
            if (!instruction_fetch_activate) begin
               state_d = IDLE;
            end else if (instruction_addr != cap_addr_q) begin
               capture = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      if (capture) begin
         if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = '0;
            rd_en   = 1'b1;
         end else begin
            state_d = WAIT;
            cnt_d   = IMEM_CNT_WIDTH'(LATENCY - 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cap_addr_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= (state_d == RESP);
         if (capture) begin
            cap_addr_q <= instruction_addr;
         end
         if (rd_en) begin
            err_q <= out_of_range | misaligned;
         end else if (state_d != RESP) begin
            err_q <= 1'b0;
         end
      end
   end

   imem_store #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_store (
      .clk   (clk),
      .we    (load_en & rst_n),
      .waddr (load_addr),
      .wdata (load_data),
      .re    (rd_en),
      .raddr (sel_addr[IDX_W+1:2]),
      .rdata (rd_data)
   );

   // Gating on registered flags only: reset zeroes data at once and errors read as zero.
   assign instruction_data        = (done_q && !err_q) ? rd_data : '0;
   assign instruction_fetch_done  = done_q;
   assign instruction_fetch_error = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized and directed bench for imem_responder against a request-age model
module tb_imem_responder;

   localparam int L     = 2;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instruction_addr;
   logic        act;
   logic [31:0] data;
   logic        done;
   logic        err;
   logic        load_en;
   logic [9:0]  load_addr;
   logic [31:0] load_data;

   int total = 0;
   int bad   = 0;

   // Model: a response is due once the same address has been presented for L consecutive cycles.
   logic [31:0] mem_m [DEPTH];
   int          age;
   logic        prev_act;
   logic [31:0] prev_addr;
   logic        exp_done;
   logic        exp_err;
   logic [31:0] exp_data;

   always #5 clk = ~clk;

   imem_responder #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (L)
   ) dut (
      .clk                        (clk),
      .rst_n                      (rst_n),
      .instruction_addr           (instruction_addr),
      .instruction_fetch_activate (act),
      .instruction_data           (data),
      .instruction_fetch_done     (done),
      .instruction_fetch_error    (err),
      .load_en                    (load_en),
      .load_addr                  (load_addr),
      .load_data                  (load_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   function automatic logic addr_err(input logic [31:0] a);
      logic e;
      e = (a[31:2] >= 30'd1024);
`ifdef IMEM_ALIGN_CHECK_EN
      e = e | (a[1:0] != 2'b00);
`endif
      return e;
   endfunction

   task automatic step(input string tag);
      @(posedge clk);
      if (!act) begin
         age = 0;
      end else if (prev_act && instruction_addr == prev_addr) begin
         if (age < 1000) age++;
      end else begin
         age = 1;
      end
      prev_act  = act;
      prev_addr = instruction_addr;
      if (act && age == L) begin
         exp_err  = addr_err(instruction_addr);
         exp_data = exp_err ? 32'h0 : mem_m[instruction_addr[11:2]];
      end
      if (load_en) mem_m[load_addr] = load_data;
      exp_done = act && (age >= L);
      #1;
      chk({tag, "_done"}, 32'(done), 32'(exp_done));
      if (exp_done) begin
         chk({tag, "_data"}, data, exp_data);
         chk({tag, "_err"}, 32'(err), 32'(exp_err));
      end
   endtask

   task automatic load_word(input int idx, input logic [31:0] val);
      load_en   = 1'b1;
      load_addr = 10'(idx);
      load_data = val;
      step("load");
      load_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; act = 1'b0; instruction_addr = '0;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      age = 0; prev_act = 1'b0; prev_addr = '0;
      exp_done = 1'b0; exp_err = 1'b0; exp_data = '0;
      #1;
      chk("reset_done", 32'(done), 0);
      chk("reset_data", data, 0);
      chk("reset_err", 32'(err), 0);
      #20 rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
      load_word(5, 32'hDEADBEEF);
      load_word(3, 32'h00000022);
      load_word(8, 32'h88888888);

      // basic fetch and indefinite hold
      act = 1'b1; instruction_addr = 32'h14;
      step("basic_cap");
      chk("basic_not_early", 32'(done), 0);
      step("basic");
      chk("basic_data_const", data, 32'hDEADBEEF);
      chk("basic_err_const", 32'(err), 0);
      for (int i = 0; i < 10; i++) begin
         step("basic_hold");
         chk("basic_hold_done", 32'(done), 1);
      end
      act = 1'b0;
      step("idle");

      // back-to-back
      act = 1'b1; instruction_addr = 32'h0;
      step("b2b_a"); step("b2b_a");
      instruction_addr = 32'h4;
      step("b2b_gap");
      chk("b2b_gap_done", 32'(done), 0);
      step("b2b_b");
      chk("b2b_b_data", data, mem_m[1]);
      act = 1'b0;
      step("idle");

      // abort
      act = 1'b1; instruction_addr = 32'h20;
      step("abort_cap");
      act = 1'b0;
      for (int i = 0; i < 4; i++) step("abort_idle");
      chk("abort_no_done", 32'(done), 0);
      act = 1'b1; instruction_addr = 32'h24;
      step("abort_next"); step("abort_next");
      chk("abort_next_data", data, mem_m[9]);
      act = 1'b0;
      step("idle");

      // out of range
      act = 1'b1; instruction_addr = 32'h1000;
      step("range"); step("range");
      chk("range_err_const", 32'(err), 1);
      chk("range_data_const", data, 0);
      act = 1'b0;
      step("idle");

      // misaligned
      act = 1'b1; instruction_addr = 32'h22;
      step("align"); step("align");
`ifdef IMEM_ALIGN_CHECK_EN
      chk("align_err_const", 32'(err), 1);
      chk("align_data_const", data, 0);
`else
      chk("align_err_const", 32'(err), 0);
      chk("align_data_const", data, 32'h88888888);
`endif
      act = 1'b0;
      step("idle");

      // reset mid-RESP with a load that must be ignored
      act = 1'b1; instruction_addr = 32'h14;
      step("rst_pre"); step("rst_pre");
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_done", 32'(done), 0);
      chk("rst_async_data", data, 0);
      chk("rst_async_err", 32'(err), 0);
      load_en = 1'b1; load_addr = 10'd5; load_data = 32'h00000BAD;
      @(posedge clk);
      #1 load_en = 1'b0;
      #3 rst_n = 1'b1;
      age = 0; prev_act = 1'b0;
      step("rst_recap");
      chk("rst_recap_early", 32'(done), 0);
      step("rst_recap");
      chk("rst_load_ignored", data, 32'hDEADBEEF);
      act = 1'b0;
      step("idle");

      // read/write collision
      act = 1'b1; instruction_addr = 32'h0C;
      step("coll_cap");
      load_en = 1'b1; load_addr = 10'd3; load_data = 32'h11;
      step("coll");
      load_en = 1'b0;
      chk("coll_old_data", data, 32'h22);
      act = 1'b0;
      step("idle");
      act = 1'b1;
      step("coll_new"); step("coll_new");
      chk("coll_new_data", data, 32'h11);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom % 4 == 0) begin
            int r;
            r = int'($urandom % 10);
            if (r < 7)      instruction_addr = {20'b0, 10'($urandom % 1024), 2'b00};
            else if (r < 9) instruction_addr = 32'h1000 + ($urandom % 64) * 4;
            else            instruction_addr = {20'b0, 10'($urandom % 1024), 2'($urandom % 4)};
         end
         act       = ($urandom % 8) != 0;
         load_en   = ($urandom % 4) == 0;
         load_addr = 10'($urandom % 1024);
         load_data = $urandom;
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, 32, byte address width of the fetch request.
REQ-002 Parameter DATA_WIDTH, 32, instruction word width.
REQ-003 Parameter DEPTH_WORDS, 1024, number of instruction words stored; a power of two, at least 2.
REQ-004 Parameter LATENCY, 2, cycles from request capture to instruction_fetch_done; legal range 1..15.
REQ-005 clk  input  1  the single clock; all state updates on posedge clk.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 instruction_addr  input  ADDR_WIDTH  byte address of the requested instruction.
REQ-008 instruction_fetch_activate  input  1  the request is valid while high.
REQ-009 instruction_data  output  DATA_WIDTH  fetched word, valid while instruction_fetch_done is high.
REQ-010 instruction_fetch_done  output  1  response valid for the current request.
REQ-011 instruction_fetch_error  output  1  qualifies done: address out of range, or misaligned when the alignment check is compiled in.
REQ-012 load_en  input  1  writes one word into the store this cycle.
REQ-013 load_addr  input  $clog2(DEPTH_WORDS)  word index for the load.
REQ-014 load_data  input  DATA_WIDTH  word to store.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
- IDLE: activate=1 captures the address, loads the counter with LATENCY-1 and moves to WAIT.
- With LATENCY=1, IDLE SHALL go straight to RESP.
REQ-016 WAIT SHALL decrement the counter each cycle and move to RESP when the counter is 0.
- On entry to RESP, data SHALL be registered from the store at the captured word index, addr[ADDR_WIDTH-1:2].
REQ-017 In RESP, done SHALL be 1, and data and error SHALL be held constant.
REQ-018 RESP SHALL be held while activate=1 and instruction_addr equals the captured address, so the requester may stall indefinitely.
REQ-019 In WAIT or RESP, activate=0 SHALL return the FSM to IDLE next cycle with done=0.
REQ-020 In WAIT or RESP, activate=1 with a different address SHALL abandon the current request and capture the new one (restart).
- The total cost is LATENCY cycles from the address change.
- A done for the abandoned request SHALL never be emitted.
REQ-021 done SHALL be 0 in IDLE and WAIT. Back-to-back distinct addresses SHALL therefore yield done pulses separated by LATENCY cycles.
REQ-022 A word index >= DEPTH_WORDS SHALL complete normally with error=1 and data=0.
REQ-023 load_en SHALL write on the clock edge. If the same word is read on the same edge, the read SHALL return the old contents. A load SHALL not disturb the FSM.
REQ-024 The store SHALL not be reset; unloaded words read as X in simulation.
REQ-025 Done, data and error SHALL be registered outputs, with no combinational path from the inputs.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, counter=0, done=0, error=0 and data=0, without waiting for a clock edge.
REQ-027 Assertion during WAIT or RESP SHALL drop the request. After release, a still-active request SHALL be recaptured and take LATENCY cycles.
REQ-028 A load_en during reset SHALL be ignored.

Configuration
REQ-029 Macro IMEM_ALIGN_CHECK_EN:
- Defined: addr[1:0]!=0 SHALL complete after LATENCY with error=1 and data=0.
- Undefined: addr[1:0] SHALL be ignored, the word is returned and error depends only on range.

Structure
REQ-030 Package imem_pkg SHALL hold the state enum imem_state_t (IDLE, WAIT, RESP) and the constants IMEM_ADDR_WIDTH=32, IMEM_DATA_WIDTH=32 and IMEM_MAX_LATENCY=15.
REQ-031 The storage array SHALL be sub-module imem_store, a single-clock RAM with one write port and one registered read port. The FSM and counter SHALL stay in imem_responder.

Verification
REQ-032 The bench SHALL cover the following directed scenarios with LATENCY=2:
- Basic fetch: load word 5=0xDEADBEEF; hold addr 0x14 with activate=1 -> done=1 two cycles after capture with data 0xDEADBEEF and error=0; done stays high for 10 held cycles.
- Back-to-back: addr 0x00 then 0x04 changed in the cycle after done -> second done 2 cycles later; no done pulse between the two responses carries stale data.
- Abort: addr 0x20 active one cycle, then activate=0 -> no done ever; then 0x24 -> done after 2 cycles.
- Range and alignment: addr 0x1000 (index 1024) -> done with error=1, data=0. addr 0x22 with IMEM_ALIGN_CHECK_EN -> error=1; without the macro -> word 8 returned with error=0.
- Reset mid-RESP: rst_n low asynchronously between edges -> done=0 before the next edge; after release with activate held -> done after 2 cycles.
- Load collision: load word 3=0x11 on the same edge RESP reads word 3 (old 0x22) -> data=0x22; the next fetch of 0x0C returns 0x11.
